// File: rtl/vga_timing_pkg.sv
// Shared raster constants for the VGA text-mode path (640x480@60, 800x525 total).
package vga_timing_pkg;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;

  localparam int unsigned V_VIS  = 480;
  localparam int unsigned V_FP   = 10;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 33;

  localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  // Internal counter width and the zero-extended width seen downstream.
  localparam int unsigned CNT_W = 10;
  localparam int unsigned OUT_W = 16;

  // Level driven on the sync pins while the pulse is active.
  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b0;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bus from the timing generator to the pixel generator and the CPU interrupt logic.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic [OUT_W-1:0] pixel_col;
  logic [OUT_W-1:0] pixel_row;
  logic             hsync_n;
  logic             vsync_n;
  logic             video_de;
  logic             frame_start;
  logic             vblank_irq;
  logic             vblank_ack;

  modport master (
    output pixel_col, pixel_row, hsync_n, vsync_n, video_de, frame_start, vblank_irq,
    input  vblank_ack
  );

  modport slave (
    input  pixel_col, pixel_row, hsync_n, vsync_n, video_de, frame_start, vblank_irq,
    output vblank_ack
  );

endinterface

// File: rtl/vga_sync_delay.sv
// N-deep, 3-bit shift register; every stage resets to ResetVal so the outputs
// show inactive levels until real decodes have propagated through.
module vga_sync_delay #(
  parameter int unsigned Depth    = 2,
  parameter logic [2:0]  ResetVal = 3'b110
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_d,
  output logic [2:0] o_q
);

  logic [2:0] r_stage [Depth];

  // Shift chain: stage 0 captures the raw decode, last stage drives the pins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(Depth); i++) r_stage[i] <= ResetVal;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < int'(Depth); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[Depth-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with delayed sync/enable, frame-start strobe and
// a sticky vertical-blank interrupt.
module vga_timing_gen #(
  parameter int unsigned H_VIS      = vga_timing_pkg::H_VIS,
  parameter int unsigned H_FP       = vga_timing_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_timing_pkg::H_BP,
  parameter int unsigned V_VIS      = vga_timing_pkg::V_VIS,
  parameter int unsigned V_FP       = vga_timing_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_timing_pkg::V_BP,
  parameter int unsigned PIPE_DELAY = 2  // legal range 1..4
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master bus
);
  import vga_timing_pkg::*;

  localparam int unsigned HTotal   = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal   = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart  = H_VIS + H_FP;
  localparam int unsigned HsEnd    = H_VIS + H_FP + H_SYNC - 1;
  localparam int unsigned VsStart  = V_VIS + V_FP;
  localparam int unsigned VsEnd    = V_VIS + V_FP + V_SYNC - 1;
  localparam logic [2:0]  Inactive = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

  logic [CNT_W-1:0] r_col, r_row;
  logic             r_frame_start, r_irq;
  logic             w_col_last, w_row_last, w_vb_set;
  logic             w_hs_act, w_vs_act, w_de;
  logic [2:0]       w_raw, w_dly;

  assign w_col_last = (r_col == CNT_W'(HTotal - 1));
  assign w_row_last = (r_row == CNT_W'(VTotal - 1));
  // Last pixel of the last visible line: next edge enters (0, V_VIS).
  assign w_vb_set   = w_col_last && (r_row == CNT_W'(V_VIS - 1));

  // Raster counters; the row advances only on the column wrap.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else begin
      r_col <= w_col_last ? '0 : r_col + 1'b1;
      if (w_col_last) r_row <= w_row_last ? '0 : r_row + 1'b1;
    end
  end

  // Raw decodes from the current counters, before alignment delay.
  always_comb begin
    w_hs_act = (r_col >= CNT_W'(HsStart)) && (r_col <= CNT_W'(HsEnd));
    w_vs_act = (r_row >= CNT_W'(VsStart)) && (r_row <= CNT_W'(VsEnd));
    w_de     = (r_col < CNT_W'(H_VIS)) && (r_row < CNT_W'(V_VIS));
    w_raw    = {w_hs_act ? HSYNC_POL : ~HSYNC_POL,
                w_vs_act ? VSYNC_POL : ~VSYNC_POL,
                w_de};
  end

  // Frame strobe registered from the wrap point, so it is high exactly at (0,0)
  // and stays low at the (0,0) reached through reset.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) r_frame_start <= 1'b0;
    else          r_frame_start <= w_col_last && w_row_last;
  end

  // Sticky vblank request; a set in the same cycle as an ack wins.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) r_irq <= 1'b0;
    else          r_irq <= w_vb_set | (r_irq & ~bus.vblank_ack);
  end

  vga_sync_delay #(
    .Depth    (PIPE_DELAY),
    .ResetVal (Inactive)
  ) u_sync_delay (
    .i_clk   (pixel_clk),
    .i_rst_n (reset_n),
    .i_d     (w_raw),
    .o_q     (w_dly)
  );

  assign bus.pixel_col   = {{(OUT_W - CNT_W){1'b0}}, r_col};
  assign bus.pixel_row   = {{(OUT_W - CNT_W){1'b0}}, r_row};
  assign bus.hsync_n     = w_dly[2];
  assign bus.vsync_n     = w_dly[1];
  assign bus.video_de    = w_dly[0];
  assign bus.frame_start = r_frame_start;
  assign bus.vblank_irq  = r_irq;

endmodule
